// File: rtl/mem_port_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_pkg
// Shared definitions for the memory read port:
//   LINE_BYTES  aligned chunk size; no access controller chunk crosses it
//   state_t     read-port FSM states
//   chunk_t     one access-controller request {addr, len(bytes-1)}
//   split_t     result of splitting a core request into one or two chunks
//   split_req() splits a core request at the LINE_BYTES boundary
// -----------------------------------------------------------------------------
package mem_port_pkg;

  localparam int unsigned LINE_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } chunk_t;

  typedef struct packed {
    logic   two;
    chunk_t c0;
    chunk_t c1;
  } split_t;

  // A request that runs past the end of its line becomes two chunks: the tail
  // of the current line and the head of the next one. The next-line address
  // is computed modulo 2^32 so requests near the top of memory wrap to 0.
  function automatic split_t split_req(input logic [31:0] addr,
                                       input logic [3:0]  len,
                                       input int unsigned line_bytes);
    split_t      s;
    logic [31:0] off;
    logic [31:0] n;
    logic [31:0] first;
    logic [31:0] base;
    s       = '0;
    off     = addr & (line_bytes - 32'd1);
    n       = {28'd0, len} + 32'd1;
    first   = line_bytes - off;
    base    = addr & ~(line_bytes - 32'd1);
    s.c0.addr = addr;
    if (off + n <= line_bytes) begin
      s.c0.len = len;
    end else begin
      s.two     = 1'b1;
      s.c0.len  = 4'(first - 32'd1);
      s.c1.addr = base + line_bytes;
      s.c1.len  = 4'(n - first - 32'd1);
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_read_port_if.sv
// -----------------------------------------------------------------------------
// mem_acc_prt_intf
// Link between a read port and the memory access controller.
//   tx_*  request channel  (front side drives av/addr/len/dat, controller re)
//   rx_*  reply channel    (controller drives av/addr/len/dat, front side re)
// Lengths encode bytes-1; rx_dat is right-justified (chunk byte 0 at [7:0]).
// -----------------------------------------------------------------------------
interface mem_acc_prt_intf;

  logic         tx_av;
  logic         tx_re;
  logic [31:0]  tx_addr;
  logic [3:0]   tx_len;
  logic [127:0] tx_dat;

  logic         rx_av;
  logic         rx_re;
  logic [31:0]  rx_addr;
  logic [3:0]   rx_len;
  logic [127:0] rx_dat;

  modport front_side (
    output tx_av, tx_addr, tx_len, tx_dat,
    input  tx_re,
    input  rx_av, rx_addr, rx_len, rx_dat,
    output rx_re
  );

  modport access_side (
    input  tx_av, tx_addr, tx_len, tx_dat,
    output tx_re,
    output rx_av, rx_addr, rx_len, rx_dat,
    input  rx_re
  );

endinterface

// File: rtl/mem_read_port.sv
// -----------------------------------------------------------------------------
// mem_read_port
// Turns a core read request (1..16 bytes at any byte address) into one or two
// line-aligned chunk requests to the memory access controller, collects the
// replies and presents the assembled little-endian data.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_go            request strobe, honoured only when idle
//   req_addr/req_len  start byte address / length in bytes-1
//   req_busy          request in flight
//   req_done          one-cycle completion pulse
//   req_err           a reply came back with an unexpected address
//   req_dat           assembled data, byte 0 at [7:0], unused bytes zero
//   mac_prt           front side of the access controller link
// -----------------------------------------------------------------------------
module mem_read_port #(
  parameter int unsigned LINE_BYTES = mem_port_pkg::LINE_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_go,
  input  logic [31:0]              req_addr,
  input  logic [3:0]               req_len,
  output logic                     req_busy,
  output logic                     req_done,
  output logic                     req_err,
  output logic [127:0]             req_dat,
  mem_acc_prt_intf.front_side      mac_prt
);

  import mem_port_pkg::*;

  state_t       state_q, state_d;
  chunk_t       c0_q, c1_q;
  logic         two_q;
  logic         err_q;
  logic [127:0] dat_q;

  split_t       split_in;
  chunk_t       exp_chunk;
  logic [3:0]   rx_keep;
  logic [127:0] rx_bytes;
  logic [7:0]   rx_shift;

  // Mask covering bytes 0..last of a 16-byte word.
  function automatic logic [127:0] byte_mask(input logic [3:0] last);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i <= int'(last)) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  assign split_in = split_req(req_addr, req_len, LINE_BYTES);

  // Reply bytes are clipped to the shorter of the reply length and the chunk
  // we asked for, so an oversized reply can never spill into other bytes.
  // The second chunk lands right after the bytes of the first one.
  always_comb begin
    exp_chunk = (state_q == WAIT1) ? c1_q : c0_q;
    rx_keep   = (mac_prt.rx_len < exp_chunk.len) ? mac_prt.rx_len : exp_chunk.len;
    rx_bytes  = mac_prt.rx_dat & byte_mask(rx_keep);
    rx_shift  = ({4'd0, c0_q.len} + 8'd1) << 3;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    mac_prt.tx_av   = 1'b0;
    mac_prt.tx_addr = '0;
    mac_prt.tx_len  = '0;
    mac_prt.rx_re   = 1'b0;
    case (state_q)
      IDLE: begin
        // Stale replies (e.g. after a mid-request reset) are drained here.
        mac_prt.rx_re = mac_prt.rx_av;
        if (req_go) state_d = ISSUE0;
      end
      ISSUE0: begin
        mac_prt.tx_av   = 1'b1;
        mac_prt.tx_addr = c0_q.addr;
        mac_prt.tx_len  = c0_q.len;
        if (mac_prt.tx_re) state_d = WAIT0;
      end
      WAIT0: begin
        mac_prt.rx_re = mac_prt.rx_av;
        if (mac_prt.rx_av) state_d = two_q ? ISSUE1 : DONE;
      end
      ISSUE1: begin
        mac_prt.tx_av   = 1'b1;
        mac_prt.tx_addr = c1_q.addr;
        mac_prt.tx_len  = c1_q.len;
        if (mac_prt.tx_re) state_d = WAIT1;
      end
      WAIT1: begin
        mac_prt.rx_re = mac_prt.rx_av;
        if (mac_prt.rx_av) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mac_prt.tx_dat = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      c0_q  <= '0;
      c1_q  <= '0;
      two_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_go) begin
            c0_q  <= split_in.c0;
            c1_q  <= split_in.c1;
            two_q <= split_in.two;
            err_q <= 1'b0;
            dat_q <= '0;
          end
        end
        WAIT0: begin
          if (mac_prt.rx_av) begin
            dat_q <= rx_bytes;
            if (mac_prt.rx_addr != c0_q.addr) err_q <= 1'b1;
          end
        end
        WAIT1: begin
          if (mac_prt.rx_av) begin
            dat_q <= dat_q | (rx_bytes << rx_shift);
            if (mac_prt.rx_addr != c1_q.addr) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_busy = (state_q != IDLE);
  assign req_done = (state_q == DONE);
  assign req_err  = err_q;
  assign req_dat  = dat_q;

endmodule

// File: tb/tb_mem_read_port.sv
// -----------------------------------------------------------------------------
// tb_mem_read_port
// Directed bench for mem_read_port. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_read_port;

  logic         clk;
  logic         rst;
  logic         req_go;
  logic [31:0]  req_addr;
  logic [3:0]   req_len;
  logic         req_busy;
  logic         req_done;
  logic         req_err;
  logic [127:0] req_dat;

  int n_tests;
  int n_fail;

  mem_acc_prt_intf u_if ();

  mem_read_port #(.LINE_BYTES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_go   (req_go),
    .req_addr (req_addr),
    .req_len  (req_len),
    .req_busy (req_busy),
    .req_done (req_done),
    .req_err  (req_err),
    .req_dat  (req_dat),
    .mac_prt  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reply(input logic [31:0] a, input logic [3:0] l, input logic [127:0] d);
    u_if.rx_av   = 1'b1;
    u_if.rx_addr = a;
    u_if.rx_len  = l;
    u_if.rx_dat  = d;
    #1;
    chk("rx_re", u_if.rx_re, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; req_go = 1'b0; req_addr = '0; req_len = '0;
    u_if.tx_re = 1'b0; u_if.rx_av = 1'b0; u_if.rx_addr = '0;
    u_if.rx_len = '0; u_if.rx_dat = '0;

    // Reset state
    step; step; #1;
    chk("rst busy",    req_busy, 0);
    chk("rst done",    req_done, 0);
    chk("rst err",     req_err, 0);
    chk("rst dat",     req_dat, 0);
    chk("rst tx_av",   u_if.tx_av, 0);
    chk("rst tx_addr", u_if.tx_addr, 0);
    chk("rst tx_len",  u_if.tx_len, 0);
    rst = 1'b0;

    // Single chunk, minimum latency
    u_if.tx_re = 1'b1;
    step; req_go = 1'b1; req_addr = 32'h0000_1004; req_len = 4'd3; #1;
    step; req_go = 1'b0; #1;
    chk("t1 tx_av",   u_if.tx_av, 1);
    chk("t1 tx_addr", u_if.tx_addr, 32'h0000_1004);
    chk("t1 tx_len",  u_if.tx_len, 3);
    chk("t1 tx_dat",  u_if.tx_dat, 0);
    chk("t1 busy",    req_busy, 1);
    step; reply(32'h0000_1004, 4'd3, 128'hDDCC_BBAA);
    chk("t1 tx_av wait", u_if.tx_av, 0);
    step; u_if.rx_av = 1'b0; #1;
    chk("t1 done c3", req_done, 1);
    chk("t1 dat",     req_dat, 128'hDDCC_BBAA);
    chk("t1 err",     req_err, 0);
    step; #1;
    chk("t1 done low", req_done, 0);
    chk("t1 idle",     req_busy, 0);
    chk("t1 dat hold", req_dat, 128'hDDCC_BBAA);

    // Two chunks across a line boundary
    step; req_go = 1'b1; req_addr = 32'h0000_100C; req_len = 4'd7; #1;
    step; req_go = 1'b0; #1;
    chk("t2 c0 addr", u_if.tx_addr, 32'h0000_100C);
    chk("t2 c0 len",  u_if.tx_len, 3);
    step; reply(32'h0000_100C, 4'd3, 128'h4433_2211);
    step; u_if.rx_av = 1'b0; #1;
    chk("t2 c1 av",   u_if.tx_av, 1);
    chk("t2 c1 addr", u_if.tx_addr, 32'h0000_1010);
    chk("t2 c1 len",  u_if.tx_len, 3);
    chk("t2 no done", req_done, 0);
    step; reply(32'h0000_1010, 4'd3, 128'h8877_6655);
    step; u_if.rx_av = 1'b0; #1;
    chk("t2 done c5", req_done, 1);
    chk("t2 dat",     req_dat, 128'h8877_6655_4433_2211);
    chk("t2 err",     req_err, 0);
    step; #1;

    // Chunk1 address wraps to zero
    step; req_go = 1'b1; req_addr = 32'hFFFF_FFF8; req_len = 4'd15; #1;
    step; req_go = 1'b0; #1;
    chk("t3 c0 len", u_if.tx_len, 7);
    step; reply(32'hFFFF_FFF8, 4'd7, 128'h0807_0605_0403_0201);
    step; u_if.rx_av = 1'b0; #1;
    chk("t3 c1 addr", u_if.tx_addr, 32'h0000_0000);
    chk("t3 c1 len",  u_if.tx_len, 7);
    step; reply(32'h0000_0000, 4'd7, 128'h100F_0E0D_0C0B_0A09);
    step; u_if.rx_av = 1'b0; #1;
    chk("t3 done", req_done, 1);
    chk("t3 dat",  req_dat, 128'h100F_0E0D_0C0B_0A09_0807_0605_0403_0201);
    chk("t3 err",  req_err, 0);
    step; #1;

    // tx stall with stable fields, req_go ignored while busy, reply masking
    u_if.tx_re = 1'b0;
    step; req_go = 1'b1; req_addr = 32'h0000_2002; req_len = 4'd1; #1;
    step; req_go = 1'b0; #1;
    chk("t4 s1 av",   u_if.tx_av, 1);
    chk("t4 s1 addr", u_if.tx_addr, 32'h0000_2002);
    step; req_go = 1'b1; req_addr = 32'h0000_5000; req_len = 4'd9; #1;
    chk("t4 s2 av",   u_if.tx_av, 1);
    chk("t4 s2 addr", u_if.tx_addr, 32'h0000_2002);
    chk("t4 s2 len",  u_if.tx_len, 1);
    step; req_go = 1'b0; #1;
    chk("t4 s3 addr", u_if.tx_addr, 32'h0000_2002);
    chk("t4 s3 len",  u_if.tx_len, 1);
    step; #1;
    chk("t4 s4 av",   u_if.tx_av, 1);
    chk("t4 s4 addr", u_if.tx_addr, 32'h0000_2002);
    step; u_if.tx_re = 1'b1; #1;
    chk("t4 xfer av",  u_if.tx_av, 1);
    chk("t4 xfer len", u_if.tx_len, 1);
    step; reply(32'h0000_2002, 4'd1, 128'hFFFF_FFFF);
    chk("t4 wait av", u_if.tx_av, 0);
    step; u_if.rx_av = 1'b0; #1;
    chk("t4 done", req_done, 1);
    chk("t4 mask", req_dat, 128'h0000_FFFF);
    step; #1;

    // Reply address mismatch
    step; req_go = 1'b1; req_addr = 32'h0000_1004; req_len = 4'd3; #1;
    step; req_go = 1'b0; #1;
    step; reply(32'h0000_2000, 4'd3, 128'h1122_3344);
    step; u_if.rx_av = 1'b0; #1;
    chk("t5 done", req_done, 1);
    chk("t5 err",  req_err, 1);
    chk("t5 dat",  req_dat, 128'h1122_3344);
    step; #1;
    chk("t5 err hold", req_err, 1);

    // Next request clears the error; reset while waiting abandons it
    step; req_go = 1'b1; req_addr = 32'h0000_3000; req_len = 4'd0; #1;
    step; req_go = 1'b0; #1;
    chk("t6 err clr", req_err, 0);
    chk("t6 tx_av",   u_if.tx_av, 1);
    step; rst = 1'b1; #1;
    chk("t6 in wait", req_busy, 1);
    step; rst = 1'b0; #1;
    chk("t6 rst busy",  req_busy, 0);
    chk("t6 rst tx_av", u_if.tx_av, 0);
    chk("t6 rst done",  req_done, 0);
    chk("t6 rst dat",   req_dat, 0);
    reply(32'h0000_3000, 4'd0, 128'hAB);
    step; u_if.rx_av = 1'b0; #1;
    chk("t6 drain done", req_done, 0);
    chk("t6 drain busy", req_busy, 0);
    chk("t6 drain dat",  req_dat, 0);
    step; #1;
    chk("t6 later done", req_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
